// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-read / single-write 64-bit word memory between three
// requesters of the cpu core: instruction fetch (read), LSU load (read) and
// LSU store (write). The read port is arbitrated round-robin between fetch
// and load, a read that collides with a same-cycle store to the same word is
// held off for a cycle so it observes the new data, and out-of-range or
// console addresses are decoded so they never touch the memory array.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   if_req_*            fetch read request (valid/addr in, ready out)
//   if_resp_*           fetch read response (valid/data out), 1 cycle later
//   ld_req_*            load read request (valid/addr in, ready out)
//   ld_resp_*           load read response (valid/data out), 1 cycle later
//   st_req_*            store request (valid/addr/data in, ready out)
//   mem_raddr/mem_rdata memory read port, data one cycle after address
//   mem_wen/waddr/wdata memory write port
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned MEM_WORDS    = 2048,
    parameter logic [63:0] CONSOLE_ADDR = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req_valid,
    input  logic [63:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_resp_valid,
    output logic [63:0] if_resp_data,

    input  logic        ld_req_valid,
    input  logic [63:0] ld_req_addr,
    output logic        ld_req_ready,
    output logic        ld_resp_valid,
    output logic [63:0] ld_resp_data,

    input  logic        st_req_valid,
    input  logic [63:0] st_req_addr,
    input  logic [63:0] st_req_data,
    output logic        st_req_ready,

    output logic [63:0] mem_raddr,
    input  logic [63:0] mem_rdata,
    output logic        mem_wen,
    output logic [63:0] mem_waddr,
    output logic [63:0] mem_wdata
);

    // Identifies which read requester a grant or response belongs to.
    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_LOAD  = 1'b1
    } requester_e;

    localparam logic [63:0] MemWordsL = 64'(MEM_WORDS);

    requester_e  rrLast_q, rrLast_d;
    logic        respPending_q, respPending_d;
    requester_e  respOwner_q, respOwner_d;
    logic        respZero_q, respZero_d;

    logic        stAccept;
    logic        stInRange;
    logic        ifBlocked;
    logic        ldBlocked;
    logic        ifCand;
    logic        ldCand;
    logic        grantIf;
    logic        grantLd;
    logic        grantAny;
    logic [63:0] grantAddr;
    logic        grantInRange;
    logic [63:0] respData;

    // Store path. The write port never stalls outside reset, so a store is
    // accepted whenever it is presented. Only real memory words and the
    // console location produce a write strobe; any other address is
    // swallowed so a stray store cannot alias into the array.
    always_comb begin
        st_req_ready = rst;
        stAccept     = st_req_valid & rst;
        stInRange    = (st_req_addr < MemWordsL) || (st_req_addr == CONSOLE_ADDR);
        mem_wen      = stAccept & stInRange;
        mem_waddr    = st_req_addr;
        mem_wdata    = st_req_data;
    end

    // Read arbitration. A read aimed at the word being written this cycle is
    // held back so that, when it retries next cycle, the memory already holds
    // the stored value. Between two eligible readers the one that did not win
    // last time gets the port. Out-of-range reads are still granted (they get
    // a zero response) but the memory sees address 0 so no bogus index is
    // driven into the array.
    always_comb begin
        ifBlocked = stAccept && (st_req_addr == if_req_addr);
        ldBlocked = stAccept && (st_req_addr == ld_req_addr);
        ifCand    = rst & if_req_valid & ~ifBlocked;
        ldCand    = rst & ld_req_valid & ~ldBlocked;

        grantIf = 1'b0;
        grantLd = 1'b0;
        if (ifCand && ldCand) begin
            if (rrLast_q == REQ_LOAD) begin
                grantIf = 1'b1;
            end else begin
                grantLd = 1'b1;
            end
        end else begin
            grantIf = ifCand;
            grantLd = ldCand;
        end

        grantAny     = grantIf | grantLd;
        grantAddr    = grantLd ? ld_req_addr : if_req_addr;
        grantInRange = grantAddr < MemWordsL;
        mem_raddr    = (grantAny && grantInRange) ? grantAddr : 64'd0;
        if_req_ready = grantIf;
        ld_req_ready = grantLd;
    end

    // Next-state for the round-robin pointer and the one-deep response
    // tracker. The tracker remembers who owns the data coming back next
    // cycle and whether that data must be forced to zero because the
    // address never reached the memory.
    always_comb begin
        rrLast_d = rrLast_q;
        if (grantIf) begin
            rrLast_d = REQ_FETCH;
        end else if (grantLd) begin
            rrLast_d = REQ_LOAD;
        end
        respPending_d = grantAny;
        respOwner_d   = grantLd ? REQ_LOAD : REQ_FETCH;
        respZero_d    = grantAny & ~grantInRange;
    end

    // State registers. Reset points the round-robin pointer at load so the
    // first tie after reset goes to fetch, and drops any response in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rrLast_q      <= REQ_LOAD;
            respPending_q <= 1'b0;
            respOwner_q   <= REQ_FETCH;
            respZero_q    <= 1'b0;
        end else begin
            rrLast_q      <= rrLast_d;
            respPending_q <= respPending_d;
            respOwner_q   <= respOwner_d;
            respZero_q    <= respZero_d;
        end
    end

    // Response steering. Data returned by the memory is routed to whoever
    // owned last cycle's grant; the other port and any port without a valid
    // response read as zero. Reset also hides a response that is in flight
    // during the cycle reset is being applied.
    always_comb begin
        respData      = respZero_q ? 64'd0 : mem_rdata;
        if_resp_valid = rst & respPending_q & (respOwner_q == REQ_FETCH);
        ld_resp_valid = rst & respPending_q & (respOwner_q == REQ_LOAD);
        if_resp_data  = if_resp_valid ? respData : 64'd0;
        ld_resp_data  = ld_resp_valid ? respData : 64'd0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. A behavioural memory sits on the
// DUT's memory port. Each scenario task drives one cycle at a time, checks
// grants and write strobes inline, and pushes the response it expects onto a
// scoreboard queue; a monitor pops and compares responses as they appear.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam logic [63:0] CONSOLE = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic        isLd;
        logic [63:0] data;
        int          due;
    } respT;

    logic        clk;
    logic        rst;
    logic        if_req_valid;
    logic [63:0] if_req_addr;
    logic        if_req_ready;
    logic        if_resp_valid;
    logic [63:0] if_resp_data;
    logic        ld_req_valid;
    logic [63:0] ld_req_addr;
    logic        ld_req_ready;
    logic        ld_resp_valid;
    logic [63:0] ld_resp_data;
    logic        st_req_valid;
    logic [63:0] st_req_addr;
    logic [63:0] st_req_data;
    logic        st_req_ready;
    logic [63:0] mem_raddr;
    logic [63:0] mem_rdata;
    logic        mem_wen;
    logic [63:0] mem_waddr;
    logic [63:0] mem_wdata;

    logic [63:0] memArr [0:2047];
    logic [63:0] expMem [0:2047];
    respT        scoreQ [$];
    respT        monEntry;
    logic        monExpIf;
    logic        monExpLd;
    logic [63:0] monExpData;
    int          tests;
    int          fails;
    int          cycleCnt;

    mem_port_arbiter #(
        .MEM_WORDS    (2048),
        .CONSOLE_ADDR (CONSOLE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (if_req_valid),
        .if_req_addr   (if_req_addr),
        .if_req_ready  (if_req_ready),
        .if_resp_valid (if_resp_valid),
        .if_resp_data  (if_resp_data),
        .ld_req_valid  (ld_req_valid),
        .ld_req_addr   (ld_req_addr),
        .ld_req_ready  (ld_req_ready),
        .ld_resp_valid (ld_resp_valid),
        .ld_resp_data  (ld_resp_data),
        .st_req_valid  (st_req_valid),
        .st_req_addr   (st_req_addr),
        .st_req_data   (st_req_data),
        .st_req_ready  (st_req_ready),
        .mem_raddr     (mem_raddr),
        .mem_rdata     (mem_rdata),
        .mem_wen       (mem_wen),
        .mem_waddr     (mem_waddr),
        .mem_wdata     (mem_wdata)
    );

    // Free-running clock: posedges at 5, 15, 25 ... negedges at 10, 20 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to date scoreboard entries.
    always @(posedge clk) begin
        cycleCnt <= cycleCnt + 1;
    end

    // Behavioural memory: synchronous write, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_wen && (mem_waddr < 64'd2048)) begin
            memArr[mem_waddr[10:0]] <= mem_wdata;
        end
        mem_rdata <= memArr[mem_raddr[10:0]];
    end

    // Response monitor: every cycle, either the queue head is due and must
    // appear on its owner's port, or both response ports must be idle. A
    // response due while reset is applied is expected to be dropped.
    always @(negedge clk) begin
        #2;
        monExpIf   = 1'b0;
        monExpLd   = 1'b0;
        monExpData = 64'd0;
        if (scoreQ.size() > 0 && scoreQ[0].due == cycleCnt) begin
            monEntry = scoreQ.pop_front();
            if (rst) begin
                monExpIf   = ~monEntry.isLd;
                monExpLd   = monEntry.isLd;
                monExpData = monEntry.data;
            end
        end
        tests++;
        if (if_resp_valid !== monExpIf) begin
            fails++;
            $display("[TB] FAIL if_resp_valid cycle %0d: got %b expected %b", cycleCnt, if_resp_valid, monExpIf);
        end
        tests++;
        if (ld_resp_valid !== monExpLd) begin
            fails++;
            $display("[TB] FAIL ld_resp_valid cycle %0d: got %b expected %b", cycleCnt, ld_resp_valid, monExpLd);
        end
        tests++;
        if (if_resp_data !== (monExpIf ? monExpData : 64'd0)) begin
            fails++;
            $display("[TB] FAIL if_resp_data cycle %0d: got %h expected %h", cycleCnt, if_resp_data, monExpIf ? monExpData : 64'd0);
        end
        tests++;
        if (ld_resp_data !== (monExpLd ? monExpData : 64'd0)) begin
            fails++;
            $display("[TB] FAIL ld_resp_data cycle %0d: got %h expected %h", cycleCnt, ld_resp_data, monExpLd ? monExpData : 64'd0);
        end
    end

    // Drives one cycle of stimulus just after the falling edge.
    task automatic applyStimulus(input logic r,
                                 input logic ifV, input logic [63:0] ifA,
                                 input logic ldV, input logic [63:0] ldA,
                                 input logic stV, input logic [63:0] stA,
                                 input logic [63:0] stD);
        @(negedge clk);
        rst          = r;
        if_req_valid = ifV;
        if_req_addr  = ifA;
        ld_req_valid = ldV;
        ld_req_addr  = ldA;
        st_req_valid = stV;
        st_req_addr  = stA;
        st_req_data  = stD;
    endtask

    // Reset held with every requester active, then released with a tie.
    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 64'd10, 1'b1, 64'd20, 1'b1, 64'd30, 64'h1234);
            #1;
            tests++;
            if ({if_req_ready, ld_req_ready, st_req_ready, mem_wen} !== 4'b0000) begin
                fails++;
                $display("[TB] FAIL reset_outputs %0d: got if/ld/st/wen=%b expected 0000", k,
                         {if_req_ready, ld_req_ready, st_req_ready, mem_wen});
            end
        end
        applyStimulus(1'b1, 1'b1, 64'd10, 1'b1, 64'd20, 1'b0, 64'd0, 64'd0);
        #1;
        tests++;
        if (if_req_ready !== 1'b1 || ld_req_ready !== 1'b0 || mem_raddr !== 64'd10) begin
            fails++;
            $display("[TB] FAIL reset_first_grant: got if=%b ld=%b raddr=%0d expected if=1 ld=0 raddr=10",
                     if_req_ready, ld_req_ready, mem_raddr);
        end
        scoreQ.push_back('{isLd: 1'b0, data: expMem[10], due: cycleCnt + 1});
    endtask

    // A lone load, then both requesters held for four cycles: grants must
    // alternate starting with fetch.
    task automatic test_contention();
        applyStimulus(1'b1, 1'b0, 64'd0, 1'b1, 64'd20, 1'b0, 64'd0, 64'd0);
        #1;
        tests++;
        if (ld_req_ready !== 1'b1 || if_req_ready !== 1'b0 || mem_raddr !== 64'd20) begin
            fails++;
            $display("[TB] FAIL single_load: got if=%b ld=%b raddr=%0d expected if=0 ld=1 raddr=20",
                     if_req_ready, ld_req_ready, mem_raddr);
        end
        scoreQ.push_back('{isLd: 1'b1, data: expMem[20], due: cycleCnt + 1});
        for (int k = 0; k < 4; k++) begin
            logic        expLd;
            logic [63:0] expAddr;
            expLd   = (k % 2) == 1;
            expAddr = expLd ? 64'd20 : 64'd10;
            applyStimulus(1'b1, 1'b1, 64'd10, 1'b1, 64'd20, 1'b0, 64'd0, 64'd0);
            #1;
            tests++;
            if (if_req_ready !== ~expLd || ld_req_ready !== expLd || mem_raddr !== expAddr) begin
                fails++;
                $display("[TB] FAIL contention %0d: got if=%b ld=%b raddr=%0d expected if=%b ld=%b raddr=%0d",
                         k, if_req_ready, ld_req_ready, mem_raddr, ~expLd, expLd, expAddr);
            end
            scoreQ.push_back('{isLd: expLd, data: expMem[expAddr[10:0]], due: cycleCnt + 1});
        end
    endtask

    // Same-cycle store and read of one word: the read waits a cycle and then
    // returns the freshly written data. Covered for both load and fetch.
    task automatic test_raw();
        applyStimulus(1'b1, 1'b1, 64'd7, 1'b1, 64'd5, 1'b1, 64'd5, 64'hDEAD);
        #1;
        tests++;
        if (ld_req_ready !== 1'b0 || if_req_ready !== 1'b1 || mem_wen !== 1'b1 ||
            mem_waddr !== 64'd5 || mem_wdata !== 64'hDEAD || mem_raddr !== 64'd7) begin
            fails++;
            $display("[TB] FAIL raw_load_block: got ld=%b if=%b wen=%b waddr=%0d wdata=%h raddr=%0d expected 0 1 1 5 dead 7",
                     ld_req_ready, if_req_ready, mem_wen, mem_waddr, mem_wdata, mem_raddr);
        end
        scoreQ.push_back('{isLd: 1'b0, data: expMem[7], due: cycleCnt + 1});
        expMem[5] = 64'hDEAD;

        applyStimulus(1'b1, 1'b0, 64'd0, 1'b1, 64'd5, 1'b0, 64'd0, 64'd0);
        #1;
        tests++;
        if (ld_req_ready !== 1'b1 || mem_raddr !== 64'd5) begin
            fails++;
            $display("[TB] FAIL raw_load_retry: got ld=%b raddr=%0d expected ld=1 raddr=5", ld_req_ready, mem_raddr);
        end
        scoreQ.push_back('{isLd: 1'b1, data: expMem[5], due: cycleCnt + 1});

        applyStimulus(1'b1, 1'b1, 64'd8, 1'b1, 64'd9, 1'b1, 64'd8, 64'hBEEF);
        #1;
        tests++;
        if (if_req_ready !== 1'b0 || ld_req_ready !== 1'b1 || mem_raddr !== 64'd9 || mem_wen !== 1'b1) begin
            fails++;
            $display("[TB] FAIL raw_fetch_block: got if=%b ld=%b raddr=%0d wen=%b expected 0 1 9 1",
                     if_req_ready, ld_req_ready, mem_raddr, mem_wen);
        end
        scoreQ.push_back('{isLd: 1'b1, data: expMem[9], due: cycleCnt + 1});
        expMem[8] = 64'hBEEF;

        applyStimulus(1'b1, 1'b1, 64'd8, 1'b0, 64'd0, 1'b0, 64'd0, 64'd0);
        #1;
        tests++;
        if (if_req_ready !== 1'b1 || mem_raddr !== 64'd8) begin
            fails++;
            $display("[TB] FAIL raw_fetch_retry: got if=%b raddr=%0d expected if=1 raddr=8", if_req_ready, mem_raddr);
        end
        scoreQ.push_back('{isLd: 1'b0, data: expMem[8], due: cycleCnt + 1});
    endtask

    // Store address decode: console and the last word write; the first word
    // past the array and a far address are accepted but dropped.
    task automatic test_store_decode();
        logic [63:0] addrTab [4];
        logic        wenTab  [4];
        addrTab = '{CONSOLE, 64'd4096, 64'd2047, 64'd2048};
        wenTab  = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            logic [63:0] d;
            d = 64'h41 + 64'(k);
            applyStimulus(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1, addrTab[k], d);
            #1;
            tests++;
            if (st_req_ready !== 1'b1 || mem_wen !== wenTab[k] || mem_waddr !== addrTab[k] || mem_wdata !== d) begin
                fails++;
                $display("[TB] FAIL store_decode %0d: got ready=%b wen=%b waddr=%h wdata=%h expected 1 %b %h %h",
                         k, st_req_ready, mem_wen, mem_waddr, mem_wdata, wenTab[k], addrTab[k], d);
            end
            if (wenTab[k] && addrTab[k] < 64'd2048) begin
                expMem[addrTab[k][10:0]] = d;
            end
        end
    endtask

    // Back-to-back loads of out-of-range, console, first-invalid and last
    // valid addresses; the invalid ones return zero without touching memory.
    task automatic test_oor_read();
        logic [63:0] addrTab [4];
        addrTab = '{64'd4096, CONSOLE, 64'd2048, 64'd2047};
        for (int k = 0; k < 4; k++) begin
            logic        inRange;
            logic [63:0] expAddr;
            inRange = addrTab[k] < 64'd2048;
            expAddr = inRange ? addrTab[k] : 64'd0;
            applyStimulus(1'b1, 1'b0, 64'd0, 1'b1, addrTab[k], 1'b0, 64'd0, 64'd0);
            #1;
            tests++;
            if (ld_req_ready !== 1'b1 || mem_raddr !== expAddr) begin
                fails++;
                $display("[TB] FAIL oor_read %0d: got ready=%b raddr=%h expected ready=1 raddr=%h",
                         k, ld_req_ready, mem_raddr, expAddr);
            end
            scoreQ.push_back('{isLd: 1'b1, data: inRange ? expMem[expAddr[10:0]] : 64'd0, due: cycleCnt + 1});
        end
    endtask

    // Streaming fetches with concurrent stores, then loads reading the
    // stored words back one per cycle.
    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            logic [63:0] fa;
            logic [63:0] sa;
            logic [63:0] sd;
            fa = 64'd100 + 64'(k);
            sa = 64'd200 + 64'(k);
            sd = 64'hC000 + 64'(k);
            applyStimulus(1'b1, 1'b1, fa, 1'b0, 64'd0, 1'b1, sa, sd);
            #1;
            tests++;
            if (if_req_ready !== 1'b1 || mem_raddr !== fa || mem_wen !== 1'b1 || mem_waddr !== sa) begin
                fails++;
                $display("[TB] FAIL b2b_fetch %0d: got if=%b raddr=%0d wen=%b waddr=%0d expected 1 %0d 1 %0d",
                         k, if_req_ready, mem_raddr, mem_wen, mem_waddr, fa, sa);
            end
            scoreQ.push_back('{isLd: 1'b0, data: expMem[fa[10:0]], due: cycleCnt + 1});
            expMem[sa[10:0]] = sd;
        end
        for (int k = 0; k < 4; k++) begin
            logic [63:0] la;
            la = 64'd200 + 64'(k);
            applyStimulus(1'b1, 1'b0, 64'd0, 1'b1, la, 1'b0, 64'd0, 64'd0);
            #1;
            tests++;
            if (ld_req_ready !== 1'b1 || mem_raddr !== la) begin
                fails++;
                $display("[TB] FAIL b2b_load %0d: got ld=%b raddr=%0d expected ld=1 raddr=%0d",
                         k, ld_req_ready, mem_raddr, la);
            end
            scoreQ.push_back('{isLd: 1'b1, data: expMem[la[10:0]], due: cycleCnt + 1});
        end
    endtask

    // Reset lands while a fetch response is in flight: it must never show,
    // and the arbiter must again favour fetch on the first tie.
    task automatic test_reset_mid_read();
        applyStimulus(1'b1, 1'b1, 64'd50, 1'b0, 64'd0, 1'b0, 64'd0, 64'd0);
        #1;
        tests++;
        if (if_req_ready !== 1'b1 || mem_raddr !== 64'd50) begin
            fails++;
            $display("[TB] FAIL midreset_grant: got if=%b raddr=%0d expected if=1 raddr=50", if_req_ready, mem_raddr);
        end
        scoreQ.push_back('{isLd: 1'b0, data: expMem[50], due: cycleCnt + 1});

        applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, 64'd0);
        #1;
        tests++;
        if (if_resp_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midreset_drop: got if_resp_valid=%b expected 0", if_resp_valid);
        end

        applyStimulus(1'b1, 1'b1, 64'd60, 1'b1, 64'd70, 1'b0, 64'd0, 64'd0);
        #1;
        tests++;
        if (if_req_ready !== 1'b1 || ld_req_ready !== 1'b0 || mem_raddr !== 64'd60) begin
            fails++;
            $display("[TB] FAIL midreset_tie: got if=%b ld=%b raddr=%0d expected if=1 ld=0 raddr=60",
                     if_req_ready, ld_req_ready, mem_raddr);
        end
        scoreQ.push_back('{isLd: 1'b0, data: expMem[60], due: cycleCnt + 1});
    endtask

    // Main sequence: initialise memory and inputs, run every scenario,
    // let the scoreboard drain, then report.
    initial begin
        tests    = 0;
        fails    = 0;
        cycleCnt = 0;
        for (int i = 0; i < 2048; i++) begin
            memArr[i] = {16'hA5A5, 16'(i), 32'(i * 7 + 1)};
            expMem[i] = {16'hA5A5, 16'(i), 32'(i * 7 + 1)};
        end
        rst          = 1'b0;
        if_req_valid = 1'b1;
        if_req_addr  = 64'd10;
        ld_req_valid = 1'b1;
        ld_req_addr  = 64'd20;
        st_req_valid = 1'b1;
        st_req_addr  = 64'd30;
        st_req_data  = 64'h1234;

        test_reset();
        test_contention();
        test_raw();
        test_store_decode();
        test_oor_read();
        test_back_to_back();
        test_reset_mid_read();

        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, 64'd0);
        end
        @(negedge clk);
        #5;
        tests++;
        if (scoreQ.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", scoreQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-read/single-write 64-bit word memory between three requesters: instruction fetch (read), LSU load (read) and LSU store (write).
- Sits between the cpu core and the memory interface (mem_raddr/mem_rdata/mem_wen/mem_waddr/mem_wdata).
- Memory read data appears one cycle after the address is presented.
- Arbitrates the read port round-robin and blocks read-after-write hazards within a cycle; also decodes the console address and out-of-range addresses.

Parameters:
- MEM_WORDS, 2048, number of 64-bit words; valid word addresses are 0..MEM_WORDS-1.
- CONSOLE_ADDR, 64'hFFFF_FFFF_FFFF_FFFF, write-only character output address.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset; rst==0 at a posedge resets the block.
- if_req_valid  in  1  fetch read request.
- if_req_addr  in  64  fetch word address.
- if_req_ready  out  1  fetch request granted this cycle.
- if_resp_valid  out  1  fetch data valid.
- if_resp_data  out  64  fetch data.
- ld_req_valid  in  1  load read request.
- ld_req_addr  in  64  load word address.
- ld_req_ready  out  1  load request granted this cycle.
- ld_resp_valid  out  1  load data valid.
- ld_resp_data  out  64  load data.
- st_req_valid  in  1  store request.
- st_req_addr  in  64  store word address.
- st_req_data  in  64  store data.
- st_req_ready  out  1  store accepted this cycle.
- mem_raddr  out  64  memory read address.
- mem_rdata  in  64  memory read data, one cycle after mem_raddr.
- mem_wen  out  1  memory write enable.
- mem_waddr  out  64  memory write address.
- mem_wdata  out  64  memory write data.

Behaviour:
- State:
  - rr_last: 0 = fetch granted last, 1 = load granted last.
  - resp_pending.
  - resp_owner: 0 = fetch, 1 = load.
  - resp_zero.
- Reset (rst==0 at posedge):
  - rr_last<=1, so fetch has priority first.
  - resp_pending<=0, resp_zero<=0.
  - While rst==0 all *_ready=0 and mem_wen=0.
  - A response pending when reset is asserted is dropped: *_resp_valid=0 the following cycle.
- Store path (combinational):
  - st_req_ready = rst.
  - Accept = st_req_valid & st_req_ready.
  - mem_waddr = st_req_addr and mem_wdata = st_req_data at all times.
  - mem_wen = accept & (addr < MEM_WORDS or addr == CONSOLE_ADDR).
  - Any other address is accepted and silently dropped (mem_wen=0).
- Read arbitration (combinational, same cycle):
  - Candidates are the fetch and load requests with valid=1.
  - A candidate is blocked if a store is accepted this cycle with st_req_addr equal to the candidate address. The write wins; the read retries next cycle and then sees the new data.
  - One unblocked candidate: it is granted.
  - Two unblocked candidates: grant the one not equal to rr_last.
  - The grant asserts the matching *_req_ready for this cycle only.
  - rr_last updates to the granted requester; it holds when there is no grant.
- mem_raddr:
  - Equals the granted address when the grant is in range.
  - Otherwise mem_raddr = 0.
- Response, exactly one cycle after a grant, with no backpressure:
  - resp_pending<=grant, resp_owner<=granted id.
  - resp_zero<=(addr>=MEM_WORDS), which covers CONSOLE_ADDR.
  - The owner's *_resp_valid=1 with data = resp_zero ? 0 : mem_rdata.
  - The non-owner's resp_valid=0.
  - resp_data=0 whenever its resp_valid=0.
- Throughput:
  - One read per cycle, back-to-back.
  - A new grant may occur in the same cycle a response is presented.
  - Read and write ports operate concurrently.
- No request is reordered within a requester. Requesters hold valid and addr stable until ready.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all valids=1 -> all readies=0, mem_wen=0, resp_valids=0. Release -> fetch granted first.
- Contention: fetch at 10 and load at 20 held for 4 cycles -> grants alternate F,L,F,L. Responses follow one cycle after each grant with memory[10] or memory[20] routed to the correct port.
- RAW block: store 0xDEAD to 5 together with load of 5 in the same cycle -> ld_req_ready=0 and mem_wen=1. Next cycle the load is granted; the response returns 0xDEAD.
- Console/out-of-range store: store 0x41 to CONSOLE_ADDR -> mem_wen=1, waddr=all-ones. Store to 4096 -> st_req_ready=1, mem_wen=0.
- Out-of-range/console read: load of 4096, then load of CONSOLE_ADDR -> mem_raddr=0; responses valid with data 0.
- Reset mid-read: fetch granted, then rst=0 at the next posedge -> if_resp_valid stays 0. After release, rr_last=1, so fetch wins a tie.
